// File: rtl/flux_rr_scheduler_if.sv
// Read side of FLUX first-word-fall-through FIFOs plus the tagged write port
// and grant status around one flux_rr_scheduler instance.
interface flux_rr_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2
);
  localparam int TAG_W = $clog2(FLUX);
  localparam int WIDTH = DATA_WIDTH + TAG_W;

  logic [FLUX*DATA_WIDTH-1:0] in_dout;
  logic [FLUX-1:0]            in_empty;
  logic [FLUX-1:0]            in_read;
  logic [WIDTH-1:0]           out_din;
  logic                       out_write;
  logic [FLUX-1:0]            out_full;
  logic [TAG_W-1:0]           grant;
  logic                       busy;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_read, out_din, out_write, grant, busy
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_read, out_din, out_write, grant, busy
  );
endinterface

// File: rtl/flux_rr_scheduler.sv
// Round-robin merge of FLUX FWFT FIFO heads into one {tag, data} write stream,
// with a per-grant burst quota and a single-entry output register.
module flux_rr_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int BURST      = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  flux_rr_scheduler_if.master bus
);
  localparam int TAG_W = $clog2(FLUX);
  localparam int CNT_W = 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [TAG_W-1:0]      grant_q, grant_d;
  logic [TAG_W-1:0]      rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_v_q;
  logic [TAG_W-1:0]      out_tag_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [FLUX-1:0]       eligible;
  logic                  out_write;
  logic                  load_en;
  logic [TAG_W-1:0]      next_ptr;
  logic [TAG_W-1:0]      arb_base;
  logic [TAG_W-1:0]      arb_tag;
  logic                  arb_found;
  logic                  pop;
  logic [TAG_W-1:0]      pop_tag;
  logic [DATA_WIDTH-1:0] pop_data;

  assign eligible  = ~bus.in_empty & ~bus.out_full;
  assign out_write = out_v_q & ~bus.out_full[out_tag_q];
  assign load_en   = ~out_v_q | out_write;
  assign next_ptr  = (int'(grant_q) == FLUX - 1) ? '0 : grant_q + 1'b1;
  // A releasing grant searches from the flux after it, so re-arbitration
  // happens in the same cycle without touching the stored pointer first.
  assign arb_base  = (state_q == S_HOLD) ? next_ptr : rr_q;

  // Walk offsets high-to-low so the lowest offset from arb_base wins.
  always_comb begin
    arb_found = 1'b0;
    arb_tag   = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(arb_base) + i) % FLUX;
      if (eligible[idx]) begin
        arb_found = 1'b1;
        arb_tag   = TAG_W'(idx);
      end
    end
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    pop_tag = grant_q;
    if (load_en) begin
      if (state_q == S_HOLD && eligible[grant_q] && cnt_q < CNT_W'(BURST)) begin
        pop   = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end else begin
        if (state_q == S_HOLD) rr_d = next_ptr;
        if (arb_found) begin
          pop     = 1'b1;
          pop_tag = arb_tag;
          grant_d = arb_tag;
          cnt_d   = CNT_W'(1);
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_comb begin
    bus.in_read = '0;
    if (pop) bus.in_read[pop_tag] = 1'b1;
  end

  assign pop_data = bus.in_dout[int'(pop_tag)*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: state registers use non-blocking assignments; reset is synchronous,
  // and a token held in the output register is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      out_v_q    <= 1'b0;
      out_tag_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (load_en) begin
        out_v_q <= pop;
        if (pop) begin
          out_tag_q  <= pop_tag;
          out_data_q <= pop_data;
        end
      end
    end
  end

  assign bus.out_din   = {out_tag_q, out_data_q};
  assign bus.out_write = out_write;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == S_HOLD);
endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed bench for flux_rr_scheduler: FLUX=2, BURST=4, FWFT FIFO models on
// the read side and an always-ready (unless out_full) consumer on the write side.
module tb_flux_rr_scheduler;
  localparam int DW    = 8;
  localparam int FLUX  = 2;
  localparam int BURST = 4;
  localparam int WIDTH = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  flux_rr_scheduler_if #(.DATA_WIDTH(DW), .FLUX(FLUX)) bus ();

  flux_rr_scheduler #(.DATA_WIDTH(DW), .FLUX(FLUX), .BURST(BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Upstream FWFT FIFO models: push() appends, in_read pops at the clock edge.
  logic [DW-1:0] mem [FLUX][64];
  int            wr_cnt [FLUX];
  int            rd_ptr [FLUX];

  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      bus.in_empty[f]         = (rd_ptr[f] == wr_cnt[f]);
      bus.in_dout[f*DW +: DW] = mem[f][rd_ptr[f] % 64];
    end
  end

  always @(posedge clk) begin
    for (int f = 0; f < FLUX; f++) begin
      if (bus.in_read[f]) begin
        if (rd_ptr[f] == wr_cnt[f]) begin
          n_err++;
          $display("FAIL pop_empty: in_read[%0d]=1 while flux %0d empty", f, f);
        end
        rd_ptr[f] <= rd_ptr[f] + 1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if ($countones(bus.in_read) > 1) begin
      n_err++;
      $display("FAIL in_read_onehot: got %b", bus.in_read);
    end
  end

  task automatic push(input int f, input logic [DW-1:0] d);
    mem[f][wr_cnt[f] % 64] = d;
    wr_cnt[f]++;
  endtask

  task automatic test_reset();
    bus.out_full = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.in_read !== 2'b00) begin n_err++; $display("FAIL rst_in_read: got %b exp 00", bus.in_read); end
    n_cmp++; if (bus.out_write !== 1'b0) begin n_err++; $display("FAIL rst_out_write: got %b exp 0", bus.out_write); end
    n_cmp++; if (bus.out_din !== 9'h000) begin n_err++; $display("FAIL rst_out_din: got %h exp 000", bus.out_din); end
    n_cmp++; if (bus.grant !== 1'b0) begin n_err++; $display("FAIL rst_grant: got %b exp 0", bus.grant); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rr_burst();
    logic [WIDTH-1:0] exp_w [12];
    logic [WIDTH-1:0] got [$];
    int first_rd = -1, first_wr = -1, last_wr = -1;
    exp_w = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h120, 9'h121,
              9'h122, 9'h123, 9'h014, 9'h015, 9'h124, 9'h125};
    for (int i = 0; i < 6; i++) begin
      push(0, DW'(8'h10 + i));
      push(1, DW'(8'h20 + i));
    end
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.in_read != 2'b00 && first_rd < 0) first_rd = c;
      if (bus.out_write) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        got.push_back(bus.out_din);
      end
      @(negedge clk);
    end
    n_cmp++; if (got.size() != 12) begin n_err++; $display("FAIL rr_count: got %0d exp 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      logic [WIDTH-1:0] g;
      g = (i < got.size()) ? got[i] : 'x;
      n_cmp++; if (g !== exp_w[i]) begin n_err++; $display("FAIL rr_word%0d: got %h exp %h", i, g, exp_w[i]); end
    end
    n_cmp++; if (first_wr !== first_rd + 1) begin n_err++; $display("FAIL rr_latency: first write cycle %0d exp %0d", first_wr, first_rd + 1); end
    n_cmp++; if (last_wr - first_wr !== 11) begin n_err++; $display("FAIL rr_contiguous: span %0d exp 11", last_wr - first_wr); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_after: busy %b exp 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got [$];
    int first_rd = -1, first_wr = -1, last_wr = -1, busy_low = 0;
    bit rd0 = 1'b0;
    for (int i = 0; i < 9; i++) push(1, DW'(8'h30 + i));
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.in_read[0]) rd0 = 1'b1;
      if (bus.in_read != 2'b00 && first_rd < 0) first_rd = c;
      if (bus.out_write) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        got.push_back(bus.out_din);
        if (!bus.busy) busy_low++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got.size() != 9) begin n_err++; $display("FAIL b2b_count: got %0d exp 9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      logic [WIDTH-1:0] g, e;
      g = (i < got.size()) ? got[i] : 'x;
      e = {1'b1, DW'(8'h30 + i)};
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL b2b_word%0d: got %h exp %h", i, g, e); end
    end
    n_cmp++; if (first_wr !== first_rd + 1) begin n_err++; $display("FAIL b2b_latency: first write cycle %0d exp %0d", first_wr, first_rd + 1); end
    n_cmp++; if (last_wr - first_wr !== 8) begin n_err++; $display("FAIL b2b_contiguous: span %0d exp 8", last_wr - first_wr); end
    n_cmp++; if (busy_low !== 0) begin n_err++; $display("FAIL b2b_busy: %0d write cycles with busy=0 exp 0", busy_low); end
    n_cmp++; if (rd0 !== 1'b0) begin n_err++; $display("FAIL b2b_rd0: in_read[0] seen %b exp 0", rd0); end
  endtask

  task automatic test_full_block();
    logic [WIDTH-1:0] got [$];
    bit rd0 = 1'b0;
    logic [1:0] first_rd = 2'b00;
    bus.out_full = 2'b01;
    push(0, 8'h40); push(0, 8'h41);
    push(1, 8'h50); push(1, 8'h51); push(1, 8'h52);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.in_read[0]) rd0 = 1'b1;
      if (bus.out_write) got.push_back(bus.out_din);
      @(negedge clk);
    end
    n_cmp++; if (rd0 !== 1'b0) begin n_err++; $display("FAIL full_rd0: in_read[0] seen %b exp 0", rd0); end
    n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL full_count: got %0d exp 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] g, e;
      g = (i < got.size()) ? got[i] : 'x;
      e = {1'b1, DW'(8'h50 + i)};
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL full_word%0d: got %h exp %h", i, g, e); end
    end
    got.delete();
    bus.out_full = 2'b00;
    #1 first_rd = bus.in_read;
    n_cmp++; if (first_rd !== 2'b01) begin n_err++; $display("FAIL full_regrant: in_read %b exp 01", first_rd); end
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.out_write) got.push_back(bus.out_din);
      @(negedge clk);
    end
    n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL full_f0_count: got %0d exp 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [WIDTH-1:0] g, e;
      g = (i < got.size()) ? got[i] : 'x;
      e = {1'b0, DW'(8'h40 + i)};
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL full_f0_word%0d: got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_hol_stall();
    push(0, 8'hAB);
    #1;
    n_cmp++; if (bus.in_read !== 2'b01) begin n_err++; $display("FAIL hol_pop: in_read %b exp 01", bus.in_read); end
    @(negedge clk);
    bus.out_full = 2'b01;
    push(1, 8'hCD);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (bus.out_write !== 1'b0) begin n_err++; $display("FAIL hol_write%0d: got %b exp 0", k, bus.out_write); end
      n_cmp++; if (bus.in_read !== 2'b00) begin n_err++; $display("FAIL hol_read%0d: got %b exp 00", k, bus.in_read); end
      @(negedge clk);
    end
    bus.out_full = 2'b00;
    #1;
    n_cmp++; if (bus.out_write !== 1'b1) begin n_err++; $display("FAIL hol_release_write: got %b exp 1", bus.out_write); end
    n_cmp++; if (bus.out_din !== 9'h0AB) begin n_err++; $display("FAIL hol_release_din: got %h exp 0ab", bus.out_din); end
    n_cmp++; if (bus.in_read !== 2'b10) begin n_err++; $display("FAIL hol_flow_pop: in_read %b exp 10", bus.in_read); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_write !== 1'b1 || bus.out_din !== 9'h1CD) begin n_err++; $display("FAIL hol_next_word: write %b din %h exp 1 1cd", bus.out_write, bus.out_din); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    push(0, 8'h60);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) push(1, DW'(8'h70 + i));
    push(0, 8'h61); push(0, 8'h62);
    #1;
    n_cmp++; if (bus.in_read !== 2'b10) begin n_err++; $display("FAIL mid_rr_start: in_read %b exp 10", bus.in_read); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1 || bus.grant !== 1'b1) begin n_err++; $display("FAIL mid_pre_reset: busy %b grant %b exp 1 1", bus.busy, bus.grant); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.out_write !== 1'b0) begin n_err++; $display("FAIL mid_write: got %b exp 0", bus.out_write); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b exp 0", bus.busy); end
    n_cmp++; if (bus.grant !== 1'b0) begin n_err++; $display("FAIL mid_grant: got %b exp 0", bus.grant); end
    n_cmp++; if (bus.out_din !== 9'h000) begin n_err++; $display("FAIL mid_din: got %h exp 000", bus.out_din); end
    n_cmp++; if (bus.in_read !== 2'b01) begin n_err++; $display("FAIL mid_first_grant: in_read %b exp 01", bus.in_read); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_write !== 1'b1 || bus.out_din !== 9'h061) begin n_err++; $display("FAIL mid_first_word: write %b din %h exp 1 061", bus.out_write, bus.out_din); end
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_drain: busy %b exp 0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_idle();
    int extra = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if (bus.in_read !== 2'b00) begin n_err++; $display("FAIL idle_read%0d: got %b exp 00", c, bus.in_read); end
      n_cmp++; if (bus.out_write !== 1'b0) begin n_err++; $display("FAIL idle_write%0d: got %b exp 0", c, bus.out_write); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy%0d: got %b exp 0", c, bus.busy); end
      @(negedge clk);
    end
    push(1, 8'h99);
    #1;
    n_cmp++; if (bus.in_read !== 2'b10) begin n_err++; $display("FAIL idle_pop: in_read %b exp 10", bus.in_read); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_write !== 1'b1) begin n_err++; $display("FAIL idle_single_write: got %b exp 1", bus.out_write); end
    n_cmp++; if (bus.out_din !== 9'h199) begin n_err++; $display("FAIL idle_single_din: got %h exp 199", bus.out_din); end
    n_cmp++; if (bus.grant !== 1'b1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL idle_grant: grant %b busy %b exp 1 1", bus.grant, bus.busy); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.out_write) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL idle_extra_writes: got %0d exp 0", extra); end
  endtask

  initial begin
    test_reset();
    test_rr_burst();
    test_back_to_back();
    test_full_block();
    test_hol_stall();
    test_reset_mid();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
